rdn_in_ctrl_unit: RTL and testbench
===================================

Name: rdn_in_ctrl_unit

Overview:
- Receive-side controller for the HEU→RDN interface. It accepts one finished HEU output vector of DEPTH words per handshake.
- It captures the vector into a local buffer, then serializes it word by word to the RDN compute pipeline over a valid/ready stream.
- It holds off the next vector until RDN signals completion.
- It sits between the HEU output buffer and the RDN datapath, and drives the RDN-side in_ready that the HEU control unit waits on.

Parameters:
- DATA_WIDTH, 8, width of one vector word.
- DEPTH, 80, words per vector. Must be ≥2. Index width IDX_W = clog2(DEPTH), a derived localparam (7 for 80).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- heu_out_ready  in  1  HEU output vector valid and stable
- heu_data  in  DEPTH*DATA_WIDTH  parallel vector; word i = bits [i*DATA_WIDTH+DATA_WIDTH-1 : i*DATA_WIDTH]
- rdn_in_ready  out  1  ready to accept a vector
- word_valid  out  1  word_data/word_idx/word_last valid
- word_ready  in  1  downstream accepts current word
- word_data  out  DATA_WIDTH  current word
- word_idx  out  IDX_W  index of current word, 0..DEPTH-1
- word_last  out  1  current word is index DEPTH-1
- rdn_done  in  1  single-cycle pulse: RDN finished processing the vector
- busy  out  1  block holds a vector (not IDLE)

Behaviour:
- Reset: async on rst_n low. State=IDLE, cnt=0, buffer cleared to all zeros. Outputs after reset: rdn_in_ready=1, word_valid=0, word_last=0, word_idx=0, word_data=0, busy=0. A reset mid-STREAM or mid-WAIT_DONE drops the held vector; no word is emitted after reset.
- States: IDLE, STREAM, WAIT_DONE.
- IDLE:
  - rdn_in_ready=1.
  - Transfer occurs when heu_out_ready=1 in IDLE, combinationally the same cycle that rdn_in_ready is high.
  - On that edge: buffer ← heu_data, cnt ← 0, state ← STREAM.
  - heu_data is sampled only on the transfer edge. Later changes are ignored.
- STREAM:
  - rdn_in_ready=0, word_valid=1, word_data=buffer[cnt], word_idx=cnt, word_last=(cnt==DEPTH-1).
  - Word is accepted on an edge with word_valid & word_ready.
  - Accept with cnt<DEPTH-1: cnt ← cnt+1.
  - Accept with cnt==DEPTH-1: cnt ← 0, state ← WAIT_DONE.
  - word_ready low: outputs hold stable, no skip, no repeat.
  - First word is presented the cycle after transfer (latency 1). Throughput is one word per cycle with word_ready tied high, so a vector streams in exactly DEPTH cycles.
- WAIT_DONE:
  - rdn_in_ready=0, word_valid=0.
  - rdn_done=1 → state ← IDLE. The next vector can be accepted the cycle after.
- rdn_done is sampled only in WAIT_DONE and ignored in IDLE/STREAM. An early pulse is lost and does not shorten WAIT_DONE.
- heu_out_ready outside IDLE is ignored.
- busy = (state != IDLE).
- cnt never exceeds DEPTH-1. No wrap past DEPTH-1; DEPTH not a power of two is legal.
- word_data/word_idx/word_last outside STREAM: word_data=buffer[0], word_idx=0, word_last=0. Consumers must qualify with word_valid.

Test Plan:
- Reset then idle: rst_n low mid-cycle → all outputs at reset values immediately; after release rdn_in_ready=1, busy=0. Hold heu_out_ready=0 for 10 cycles → no state change.
- Basic vector: DEPTH=80, heu_data word i = i+1, heu_out_ready pulse, word_ready=1 → word_valid rises next cycle, emits 1,2,…,80 on 80 consecutive cycles with word_idx 0..79. word_last only on value 80, then word_valid=0. rdn_done pulse 5 cycles later → rdn_in_ready=1 the following cycle.
- Backpressure: word_ready toggled 1,0,0,1,… → every word emitted exactly once in order, outputs stable while word_ready=0, total accepted count 80.
- Ignored inputs: second heu_out_ready and a changed heu_data during STREAM; an rdn_done pulse at word 40 → stream unchanged, block stays in WAIT_DONE after word 79 until a fresh rdn_done.
- Reset mid-operation: assert rst_n low at word_idx=37 → word_valid=0 and rdn_in_ready=1 immediately, buffer zero. A new vector streams from index 0.
- Back-to-back: heu_out_ready held high continuously with rdn_done pulsed on the first WAIT_DONE cycle → next transfer on the cycle after IDLE is entered, with a 2-cycle gap in word_valid between vectors.

Source files
------------

// File: rtl/rdn_in_ctrl_unit.sv
// rdn_in_ctrl_unit: captures one HEU output vector and streams it
// word by word to the RDN pipeline, then waits for rdn_done.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   heu_out_ready, heu_data  incoming vector handshake and payload
//   rdn_in_ready             high in IDLE; vector transfer qualifier
//   word_valid/word_ready    outgoing word stream handshake
//   word_data/idx/last       current word, its index, last-word flag
//   rdn_done                 RDN finished the vector (WAIT_DONE only)
//   busy                     a vector is held
module rdn_in_ctrl_unit #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 80,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        heu_out_ready,
  input  logic [DEPTH*DATA_WIDTH-1:0] heu_data,
  output logic                        rdn_in_ready,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic [DATA_WIDTH-1:0]       word_data,
  output logic [IDX_W-1:0]            word_idx,
  output logic                        word_last,
  input  logic                        rdn_done,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [DEPTH];
  logic                  load;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load         = 1'b0;
    rdn_in_ready = 1'b0;
    word_valid   = 1'b0;
    word_idx     = '0;
    word_last    = 1'b0;
    word_data    = buf_q[0];
    unique case (state_q)
      IDLE: begin
        rdn_in_ready = 1'b1;
        if (heu_out_ready) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        word_valid = 1'b1;
        word_idx   = cnt_q;
        word_data  = buf_q[cnt_q];
        word_last  = (cnt_q == LAST);
        if (word_ready) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = WAIT_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (rdn_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // heu_data is only looked at on the transfer edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < DEPTH; i++)
        buf_q[i] <= heu_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_rdn_in_ctrl_unit.sv
// tb_rdn_in_ctrl_unit: directed table plus hand sequences
// for the rdn_in_ctrl_unit stream controller.
module tb_rdn_in_ctrl_unit;

  localparam int DW    = 8;
  localparam int DEPTH = 80;
  localparam int IDX_W = 7;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  heu_out_ready = 1'b0;
  logic [DEPTH*DW-1:0]   heu_data = '0;
  logic                  rdn_in_ready;
  logic                  word_valid;
  logic                  word_ready = 1'b0;
  logic [DW-1:0]         word_data;
  logic [IDX_W-1:0]      word_idx;
  logic                  word_last;
  logic                  rdn_done = 1'b0;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic hr;
    logic wr;
    logic dn;
    int   rdy;
    int   val;
    int   bsy;
    int   idx;
    int   data;
    int   last;
  } vec_t;

  vec_t tbl [8];

  rdn_in_ctrl_unit #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .heu_out_ready(heu_out_ready),
    .heu_data(heu_data),
    .rdn_in_ready(rdn_in_ready),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_data(word_data),
    .word_idx(word_idx),
    .word_last(word_last),
    .rdn_done(rdn_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int wexp(input int mult, input int add, input int i);
    return (i * mult + add) & 255;
  endfunction

  task automatic load_vec(input int mult, input int add);
    for (int i = 0; i < DEPTH; i++)
      heu_data[i*DW +: DW] = DW'(wexp(mult, add, i));
  endtask

  // mode 0: word_ready high; mode 1: 1,0,0 pattern plus ignored pokes
  task automatic run_stream(input int mult, input int add,
                            input int start, input int mode,
                            input bit keep_hr, output int acc);
    int exp_i;
    bit poked;
    bit wr;
    exp_i = start;
    poked = 1'b0;
    acc = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rdn_done = 1'b0;
      heu_out_ready = keep_hr;
      if (!word_valid) break;
      chk("word_idx", int'(word_idx), exp_i);
      chk("word_data", int'(word_data), wexp(mult, add, exp_i));
      chk("word_last", int'(word_last), int'(exp_i == DEPTH - 1));
      wr = (mode == 0) || (c % 3 == 0);
      if (mode == 1 && exp_i == 40 && !poked) begin
        poked = 1'b1;
        rdn_done = 1'b1;
        heu_out_ready = 1'b1;
        heu_data = {DEPTH{8'hAA}};
      end
      word_ready = wr;
      if (wr) begin
        exp_i++;
        acc++;
      end
    end
    chk("stream_end_valid", int'(word_valid), 0);
    chk("stream_end_busy", int'(busy), 1);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_rdy"}, int'(rdn_in_ready), 1);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_valid"}, int'(word_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 0, 1, 1, 0, 1, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 0, 1, 1, 1, 2, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 0, 1, 1, 1, 2, 0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 0, 1, 1, 1, 2, 0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 0, 1, 1, 2, 3, 0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 0, 1, 1, 3, 4, 0};

    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_idx", int'(word_idx), 0);
    chk("reset_data", int'(word_data), 0);
    chk("reset_last", int'(word_last), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_idle("idle_hold");
    end

    load_vec(1, 1);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy", r), int'(rdn_in_ready), tbl[r].rdy);
      chk($sformatf("tbl%0d_val", r), int'(word_valid), tbl[r].val);
      chk($sformatf("tbl%0d_busy", r), int'(busy), tbl[r].bsy);
      chk($sformatf("tbl%0d_idx", r), int'(word_idx), tbl[r].idx);
      chk($sformatf("tbl%0d_data", r), int'(word_data), tbl[r].data);
      chk($sformatf("tbl%0d_last", r), int'(word_last), tbl[r].last);
      heu_out_ready = tbl[r].hr;
      word_ready = tbl[r].wr;
      rdn_done = tbl[r].dn;
    end
    run_stream(1, 1, 4, 0, 1'b0, acc);
    chk("basic_total", acc + 4, DEPTH);

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("wait_rdy", int'(rdn_in_ready), 0);
      chk("wait_busy", int'(busy), 1);
      chk("wait_valid", int'(word_valid), 0);
      chk("wait_idx", int'(word_idx), 0);
      chk("wait_last", int'(word_last), 0);
      if (k == 4) rdn_done = 1'b1;
    end
    @(negedge clk);
    rdn_done = 1'b0;
    chk_idle("after_done");

    load_vec(3, 7);
    heu_out_ready = 1'b1;
    run_stream(3, 7, 0, 1, 1'b0, acc);
    chk("bp_total", acc, DEPTH);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("early_done_lost_busy", int'(busy), 1);
    end
    rdn_done = 1'b1;
    @(negedge clk);
    rdn_done = 1'b0;
    chk_idle("bp_done");

    load_vec(1, 1);
    heu_out_ready = 1'b1;
    run_stream(1, 1, 0, 0, 1'b1, acc);
    chk("b2b_first_total", acc, DEPTH);
    rdn_done = 1'b1;
    @(negedge clk);
    rdn_done = 1'b0;
    chk("b2b_gap_valid", int'(word_valid), 0);
    chk("b2b_gap_rdy", int'(rdn_in_ready), 1);
    load_vec(5, 2);
    run_stream(5, 2, 0, 0, 1'b0, acc);
    chk("b2b_second_total", acc, DEPTH);
    rdn_done = 1'b1;
    @(negedge clk);
    rdn_done = 1'b0;
    chk_idle("b2b_done");

    load_vec(1, 1);
    heu_out_ready = 1'b1;
    word_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      heu_out_ready = 1'b0;
      if (word_valid && word_idx == 7'd37) break;
    end
    chk("pre_reset_idx", int'(word_idx), 37);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("midreset");
    chk("midreset_data", int'(word_data), 0);
    chk("midreset_idx", int'(word_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");
    chk("post_reset_data", int'(word_data), 0);
    load_vec(7, 3);
    heu_out_ready = 1'b1;
    run_stream(7, 3, 0, 0, 1'b0, acc);
    chk("post_reset_total", acc, DEPTH);
    rdn_done = 1'b1;
    @(negedge clk);
    rdn_done = 1'b0;
    chk_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
